// File: rtl/usb_rx_sequencer.sv
// ---------------------------------------------------------------------------------------------
// usb_rx_sequencer
//
// Sequences the USB receive datapath between the NRZI decoder and the bit unstuffer. It hunts
// for SYNC on the decoded bit stream, then forwards the packet bits to the unstuffer. The
// forwarded packet is framed with start_unstuffer / end_unstuffer. The sequencer checks the EOP,
// polices the packet length and waits for the unstuffer to drain before accepting the next
// packet. A framing error produces a one-cycle abort and an error code for the protocol FSM.
//
// Parameters
//   MAX_BITS        maximum post-SYNC bits forwarded per packet (stuff bits included)
//   DRAIN_MAX       maximum cycles spent waiting for unstuff_ready after EOP
//
// Ports
//   clk             sole clock, all logic on posedge
//   rst             synchronous active-high reset
//   bit_in          NRZI-decoded bit, one per cycle
//   se0             line is SE0 this cycle
//   line_j          line is J this cycle
//   unstuff_ready   unstuffer idle
//   host_abort      protocol FSM cancels reception
//   s_out           registered forwarded bit, to unstuffer s_in
//   start_unstuffer one-cycle pulse aligned with the first PID bit on s_out
//   end_unstuffer   one-cycle pulse on the cycle after the last data bit
//   abort           one-cycle pulse, to unstuffer abort
//   rx_active       packet in flight (start_unstuffer cycle through pkt_done/abort cycle)
//   pkt_done        one-cycle pulse on clean packet completion
//   err_code        0 none, 1 short, 2 babble, 3 bad EOP / drain timeout; held until next start
// ---------------------------------------------------------------------------------------------
module usb_rx_sequencer #(
    parameter int unsigned MAX_BITS  = 1100,
    parameter int unsigned DRAIN_MAX = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       se0,
    input  logic       line_j,
    input  logic       unstuff_ready,
    input  logic       host_abort,
    output logic       s_out,
    output logic       start_unstuffer,
    output logic       end_unstuffer,
    output logic       abort,
    output logic       rx_active,
    output logic       pkt_done,
    output logic [1:0] err_code
);

    localparam int unsigned CntW   = $clog2(MAX_BITS + 1);
    localparam int unsigned DrainW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

    localparam logic [CntW-1:0]   CntMax    = CntW'(MAX_BITS);
    localparam logic [CntW-1:0]   CntMinEop = CntW'(8);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_MAX - 1);

    localparam logic [1:0] ErrNone   = 2'd0;
    localparam logic [1:0] ErrShort  = 2'd1;
    localparam logic [1:0] ErrBabble = 2'd2;
    localparam logic [1:0] ErrEop    = 2'd3;

    localparam logic [7:0] SyncPattern = 8'b0000_0001;

    typedef enum logic [2:0] {
        StHunt,
        StRecv,
        StEop1,
        StEop2,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [7:0]        sync_sr_q, sync_sr_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;

    logic       s_out_q, s_out_d;
    logic       start_q, start_d;
    logic       end_q, end_d;
    logic       abort_q, abort_d;
    logic       rx_active_q, rx_active_d;
    logic       pkt_done_q, pkt_done_d;
    logic [1:0] err_q, err_d;

    // Decoded events of the current cycle, shared by the datapath and output logic.
    logic       ev_match;
    logic       ev_fwd;
    logic       ev_end;
    logic       ev_abort;
    logic       ev_done;
    logic       ev_drain_inc;
    logic       ev_drain_clr;
    logic       err_upd;
    logic [1:0] err_new;

    logic [7:0] sync_cand;

    assign sync_cand = {sync_sr_q[6:0], bit_in};

    // -----------------------------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHunt;
            sync_sr_q   <= '0;
            bit_cnt_q   <= '0;
            drain_cnt_q <= '0;
            s_out_q     <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            abort_q     <= 1'b0;
            rx_active_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_q       <= ErrNone;
        end else begin
            state_q     <= state_d;
            sync_sr_q   <= sync_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            s_out_q     <= s_out_d;
            start_q     <= start_d;
            end_q       <= end_d;
            abort_q     <= abort_d;
            rx_active_q <= rx_active_d;
            pkt_done_q  <= pkt_done_d;
            err_q       <= err_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state and event decode
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ev_match     = 1'b0;
        ev_fwd       = 1'b0;
        ev_end       = 1'b0;
        ev_abort     = 1'b0;
        ev_done      = 1'b0;
        ev_drain_inc = 1'b0;
        ev_drain_clr = 1'b0;
        err_upd      = 1'b0;
        err_new      = ErrNone;

        unique case (state_q)
            StHunt: begin
                // A host abort in HUNT only flushes the SYNC shifter, so it also masks a match.
                // A match while the unstuffer is still busy is dropped.
                if (!host_abort && (sync_cand == SyncPattern) && unstuff_ready) begin
                    ev_match = 1'b1;
                    state_d  = StRecv;
                end
            end

            StRecv: begin
                if (host_abort) begin
                    ev_abort = 1'b1;
                end else if (se0) begin
                    if (bit_cnt_q < CntMinEop) begin
                        ev_abort = 1'b1;
                        err_upd  = 1'b1;
                        err_new  = ErrShort;
                    end else begin
                        ev_end  = 1'b1;
                        state_d = StEop1;
                    end
                end else if (bit_cnt_q == CntMax) begin
                    ev_abort = 1'b1;
                    err_upd  = 1'b1;
                    err_new  = ErrBabble;
                end else begin
                    ev_fwd = 1'b1;
                end
            end

            StEop1: begin
                if (host_abort) begin
                    ev_abort = 1'b1;
                end else if (se0) begin
                    state_d = StEop2;
                end else begin
                    ev_abort = 1'b1;
                    err_upd  = 1'b1;
                    err_new  = ErrEop;
                end
            end

            StEop2: begin
                if (host_abort) begin
                    ev_abort = 1'b1;
                end else if (line_j) begin
                    ev_drain_clr = 1'b1;
                    state_d      = StDrain;
                end else begin
                    ev_abort = 1'b1;
                    err_upd  = 1'b1;
                    err_new  = ErrEop;
                end
            end

            StDrain: begin
                if (host_abort) begin
                    ev_abort = 1'b1;
                end else if (unstuff_ready) begin
                    ev_done = 1'b1;
                    state_d = StHunt;
                end else if (drain_cnt_q == DrainLast) begin
                    ev_abort = 1'b1;
                    err_upd  = 1'b1;
                    err_new  = ErrEop;
                end else begin
                    ev_drain_inc = 1'b1;
                end
            end

            default: begin
                state_d = StHunt;
            end
        endcase

        if (ev_abort) begin
            state_d = StHunt;
        end
    end

    // -----------------------------------------------------------------------------------------
    // SYNC shifter and counters
    // -----------------------------------------------------------------------------------------
    always_comb begin
        sync_sr_d   = sync_sr_q;
        bit_cnt_d   = bit_cnt_q;
        drain_cnt_d = drain_cnt_q;

        // The shifter only runs in HUNT; it is flushed on a match, a host abort or any abort.
        if (state_q == StHunt) begin
            if (host_abort || ev_match) begin
                sync_sr_d = '0;
            end else begin
                sync_sr_d = sync_cand;
            end
        end else if (ev_abort) begin
            sync_sr_d = '0;
        end

        if (ev_match || ev_abort) begin
            bit_cnt_d = '0;
        end else if (ev_fwd) begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
        end

        if (ev_drain_clr || ev_abort) begin
            drain_cnt_d = '0;
        end else if (ev_drain_inc) begin
            drain_cnt_d = drain_cnt_q + DrainW'(1);
        end
    end

    // -----------------------------------------------------------------------------------------
    // Registered outputs
    // -----------------------------------------------------------------------------------------
    always_comb begin
        s_out_d    = ev_fwd ? bit_in : 1'b0;
        start_d    = ev_fwd && (bit_cnt_q == '0);
        end_d      = ev_end;
        abort_d    = ev_abort;
        pkt_done_d = ev_done;

        // Delayed view of the state so rx_active spans the start pulse through the pkt_done or
        // abort pulse.
        rx_active_d = (state_q != StHunt);

        err_d = err_q;
        if (start_d) begin
            err_d = ErrNone;
        end else if (err_upd) begin
            err_d = err_new;
        end
    end

    assign s_out           = s_out_q;
    assign start_unstuffer = start_q;
    assign end_unstuffer   = end_q;
    assign abort           = abort_q;
    assign rx_active       = rx_active_q;
    assign pkt_done        = pkt_done_q;
    assign err_code        = err_q;

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_usb_rx_sequencer
//
// Directed bench. Two instances share the stimulus:
//   dut   default parameters (MAX_BITS 1100, DRAIN_MAX 64)
//   dut_b small limits (MAX_BITS 20, DRAIN_MAX 8) for the babble and drain-timeout cases
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Idle bit_in is 0 so that SYNC matches happen only where the bench places them.
// ---------------------------------------------------------------------------------------------
module tb_usb_rx_sequencer;

    logic clk;
    logic rst;
    logic bit_in;
    logic se0;
    logic line_j;
    logic unstuff_ready;
    logic host_abort;

    logic       s_out, start_unstuffer, end_unstuffer, abort, rx_active, pkt_done;
    logic [1:0] err_code;
    logic       b_s_out, b_start, b_end, b_abort, b_rx_active, b_pkt_done;
    logic [1:0] b_err_code;

    int n_cmp;
    int n_bad;

    usb_rx_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .bit_in          (bit_in),
        .se0             (se0),
        .line_j          (line_j),
        .unstuff_ready   (unstuff_ready),
        .host_abort      (host_abort),
        .s_out           (s_out),
        .start_unstuffer (start_unstuffer),
        .end_unstuffer   (end_unstuffer),
        .abort           (abort),
        .rx_active       (rx_active),
        .pkt_done        (pkt_done),
        .err_code        (err_code)
    );

    usb_rx_sequencer #(
        .MAX_BITS  (20),
        .DRAIN_MAX (8)
    ) dut_b (
        .clk             (clk),
        .rst             (rst),
        .bit_in          (bit_in),
        .se0             (se0),
        .line_j          (line_j),
        .unstuff_ready   (unstuff_ready),
        .host_abort      (host_abort),
        .s_out           (b_s_out),
        .start_unstuffer (b_start),
        .end_unstuffer   (b_end),
        .abort           (b_abort),
        .rx_active       (b_rx_active),
        .pkt_done        (b_pkt_done),
        .err_code        (b_err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Seven zeros then the final 1; returns one cycle after the final SYNC bit.
    task automatic send_sync();
        for (int i = 0; i < 7; i++) begin
            bit_in = 1'b0;
            step();
        end
        bit_in = 1'b1;
        step();
        bit_in = 1'b0;
    endtask

    logic [15:0] pkt;
    logic [15:0] cap16;
    logic [19:0] bb;
    logic [19:0] cap20;
    int          starts;
    int          flag;
    int          ab_main;
    int          ab_b;

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bit_in        = 1'b0;
        se0           = 1'b0;
        line_j        = 1'b0;
        unstuff_ready = 1'b1;
        host_abort    = 1'b0;
        step();
        step();
        check("reset_outputs", {s_out, start_unstuffer, end_unstuffer, abort, rx_active,
                                pkt_done, err_code}, 8'h00);
        check("reset_outputs_b", {b_s_out, b_start, b_end, b_abort, b_rx_active, b_pkt_done,
                                  b_err_code}, 8'h00);
        rst = 1'b0;
        step();
        check("idle_rx_active", rx_active, 1'b0);

        // ---- Clean packet: PID 8'hA5 then data 8'h3C, LSB first ----
        pkt    = 16'h3CA5;
        cap16  = '0;
        starts = 0;
        send_sync();
        for (int i = 0; i < 16; i++) begin
            bit_in = pkt[i];
            step();
            cap16[i] = s_out;
            if (start_unstuffer) starts++;
            if (i == 0) begin
                check("clean_start_first_bit", start_unstuffer, 1'b1);
                check("clean_rx_active", rx_active, 1'b1);
            end
        end
        check("clean_bits", cap16, pkt);
        check("clean_start_count", starts, 1);
        bit_in = 1'b0;
        se0    = 1'b1;
        step();
        check("clean_end_pulse", end_unstuffer, 1'b1);
        step();
        check("clean_end_once", end_unstuffer, 1'b0);
        se0           = 1'b0;
        line_j        = 1'b1;
        unstuff_ready = 1'b0;
        step();
        line_j = 1'b0;
        flag   = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (pkt_done || abort) flag++;
        end
        check("clean_no_early_done", flag, 0);
        unstuff_ready = 1'b1;
        step();
        check("clean_pkt_done", pkt_done, 1'b1);
        check("clean_err_code", err_code, 2'd0);
        check("clean_rx_active_at_done", rx_active, 1'b1);
        step();
        check("clean_done_pulse_end", pkt_done, 1'b0);
        check("clean_rx_active_off", rx_active, 1'b0);

        // ---- Short packet: 5 bits then SE0 ----
        send_sync();
        for (int i = 0; i < 5; i++) begin
            bit_in = i[0];
            step();
        end
        bit_in = 1'b0;
        se0    = 1'b1;
        step();
        check("short_abort", abort, 1'b1);
        check("short_err", err_code, 2'd1);
        check("short_no_end", end_unstuffer, 1'b0);
        se0 = 1'b0;
        step();
        check("short_abort_pulse_end", abort, 1'b0);
        check("short_back_to_hunt", rx_active, 1'b0);

        // ---- Back-pressure: SYNC while unstuffer busy is ignored ----
        unstuff_ready = 1'b0;
        flag          = 0;
        send_sync();
        for (int i = 0; i < 4; i++) begin
            step();
            if (start_unstuffer || rx_active) flag++;
        end
        check("bp_no_start", flag, 0);
        check("bp_err_held", err_code, 2'd1);
        unstuff_ready = 1'b1;

        // ---- Accepted SYNC followed by 25 bits: babble on dut_b (limit 20) ----
        bb      = 20'hB5A3C;
        cap20   = '0;
        ab_main = 0;
        ab_b    = -1;
        send_sync();
        for (int i = 0; i < 25; i++) begin
            bit_in = (i < 20) ? bb[i] : 1'b0;
            step();
            if (i == 0) begin
                check("bp_later_sync_start", start_unstuffer, 1'b1);
                check("start_clears_err", err_code, 2'd0);
            end
            if (i < 20) cap20[i] = b_s_out;
            if (b_abort && ab_b < 0) ab_b = i;
            if (abort) ab_main++;
        end
        bit_in = 1'b0;
        check("babble_bits", cap20, bb);
        check("babble_abort_cycle", ab_b, 20);
        check("babble_err", b_err_code, 2'd2);
        check("long_pkt_no_abort_main", ab_main, 0);

        // ---- Bad EOP on dut: SE0 then K ----
        se0 = 1'b1;
        step();
        check("badeop_end", end_unstuffer, 1'b1);
        se0 = 1'b0;
        step();
        check("badeop_abort", abort, 1'b1);
        check("badeop_err", err_code, 2'd3);
        check("badeop_no_end", end_unstuffer, 1'b0);
        step();
        check("badeop_hunt", rx_active, 1'b0);

        // ---- Drain timeout: clean EOP, unstuff_ready held low ----
        send_sync();
        for (int i = 0; i < 10; i++) begin
            bit_in = i[0];
            step();
            if (i == 0) check("drain_start_clears_err", err_code, 2'd0);
        end
        bit_in = 1'b0;
        se0    = 1'b1;
        step();
        step();
        se0           = 1'b0;
        line_j        = 1'b1;
        unstuff_ready = 1'b0;
        step();
        line_j  = 1'b0;
        ab_main = -1;
        ab_b    = -1;
        for (int k = 0; k < 70; k++) begin
            step();
            if (abort && ab_main < 0) ab_main = k;
            if (b_abort && ab_b < 0) ab_b = k;
        end
        check("drain_timeout_cycle", ab_main, 63);
        check("drain_timeout_cycle_b", ab_b, 7);
        check("drain_err", err_code, 2'd3);
        check("drain_err_b", b_err_code, 2'd3);
        check("drain_no_done", pkt_done, 1'b0);
        unstuff_ready = 1'b1;

        // ---- Host abort mid-RECV ----
        send_sync();
        for (int i = 0; i < 4; i++) begin
            bit_in = 1'b1;
            step();
        end
        bit_in     = 1'b0;
        host_abort = 1'b1;
        step();
        host_abort = 1'b0;
        check("host_abort_pulse", abort, 1'b1);
        check("host_abort_pulse_b", b_abort, 1'b1);
        check("host_abort_err_unchanged", err_code, 2'd0);
        step();
        check("host_abort_pulse_end", abort, 1'b0);
        check("host_abort_hunt", rx_active, 1'b0);
        send_sync();
        bit_in = 1'b1;
        step();
        check("host_abort_next_sync", start_unstuffer, 1'b1);

        // ---- Reset mid-packet ----
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1;
            step();
        end
        check("rst_precondition_active", rx_active, 1'b1);
        bit_in = 1'b0;
        rst    = 1'b1;
        step();
        check("rst_mid_outputs", {s_out, start_unstuffer, end_unstuffer, abort, rx_active,
                                  pkt_done, err_code}, 8'h00);
        check("rst_mid_outputs_b", {b_s_out, b_start, b_end, b_abort, b_rx_active, b_pkt_done,
                                    b_err_code}, 8'h00);
        rst = 1'b0;
        step();
        check("rst_mid_no_abort", abort, 1'b0);
        check("rst_mid_hunt", rx_active, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
